// File: rtl/regfile_cmd_pkg.sv
// Shared constants and FSM state encoding
// for the register-file command bridge.
package regfile_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    W_COMMIT,
    ACK,
    R_ADDR,
    R_LATCH,
    R_SEND
  } state_t;

endpackage

// File: rtl/regfile_cmd_bridge_if.sv
// Byte-stream handshake bundle: command bytes in,
// response bytes out, both valid/ready.
interface regfile_cmd_bridge_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

endinterface

// File: rtl/regfile_cmd_bridge.sv
// Byte-stream command parser driving the register file
// write/read ports and returning acks / read data.
module regfile_cmd_bridge
  import regfile_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  regfile_cmd_bridge_if.slave bus,
  output logic [DEPTH-1:0] rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             rf_we,
  output logic [DEPTH-1:0] rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             busy,
  output logic             err
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] txsh;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state and state-decoded outputs; all low in reset
  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    rf_we         = 1'b0;
    busy          = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            if (bus.in_data == OP_WRITE)
              nxt = W_ADDR;
            else if (bus.in_data == OP_READ)
              nxt = R_ADDR;
          end
        end
        W_ADDR: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) nxt = W_DATA;
        end
        W_DATA: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid && cnt == LAST)
            nxt = W_COMMIT;
        end
        W_COMMIT: begin
          rf_we = 1'b1;
          nxt   = ACK;
        end
        ACK: begin
          bus.out_valid = 1'b1;
          bus.out_data  = RSP_ACK;
          if (bus.out_ready) nxt = IDLE;
        end
        R_ADDR: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) nxt = R_LATCH;
        end
        R_LATCH: nxt = R_SEND;
        R_SEND: begin
          bus.out_valid = 1'b1;
          bus.out_data  = txsh[WIDTH-1 -: 8];
          if (bus.out_ready && cnt == LAST)
            nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Address latches, rx/tx byte shifters, byte counter, err pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_raddr <= '0;
      txsh     <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == IDLE) && bus.in_valid &&
             (bus.in_data != OP_WRITE) &&
             (bus.in_data != OP_READ);
      case (state)
        W_ADDR: if (bus.in_valid) begin
          rf_waddr <= bus.in_data[DEPTH-1:0];
          cnt      <= '0;
        end
        W_DATA: if (bus.in_valid) begin
          rf_wdata <= WIDTH'({rf_wdata, bus.in_data});
          cnt      <= cnt + 1'b1;
        end
        R_ADDR: if (bus.in_valid) begin
          rf_raddr <= bus.in_data[DEPTH-1:0];
          cnt      <= '0;
        end
        R_LATCH: txsh <= rf_rdata;
        R_SEND: if (bus.out_ready) begin
          txsh <= txsh << 8;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_cmd_bridge.sv
// Randomized self-checking bench for regfile_cmd_bridge
// with an attached register file and a scoreboard model.
module tb_regfile_cmd_bridge;
  import regfile_cmd_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_cmd_bridge_if bif();

  logic [7:0]  rf_waddr;
  logic [7:0]  rf_raddr;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic        busy;
  logic        err;

  regfile_cmd_bridge #(.DEPTH(8), .WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bif.slave),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_we    (rf_we),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .busy     (busy),
    .err      (err)
  );

  // Register file paired with the bridge
  logic [15:0] rf_mem [256] = '{default: 16'h0000};
  assign rf_rdata = rf_mem[rf_raddr];

  int          we_cnt = 0;
  logic [23:0] we_q[$];

  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
      we_q.push_back({rf_waddr, rf_wdata});
      we_cnt++;
    end
  end

  // Scoreboard: expected register contents
  logic [15:0] model [256] = '{default: 16'h0000};
  int n_chk  = 0;
  int n_fail = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    n = 0;
    repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    while (bif.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, bif.in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input int maxstall);
    int n;
    n = 0;
    bif.out_ready = 1'b0;
    repeat ($urandom_range(maxstall, 0)) @(negedge clk);
    bif.out_ready = 1'b1;
    while (bif.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    b = bif.out_data;
    n_chk++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL recv_timeout out_valid=%b required 1", bif.out_valid);
    end else begin
      @(posedge clk);
      #1;
    end
    bif.out_ready = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d,
                          input int gap, input int stall);
    logic [7:0] b;
    we_q.delete();
    send_byte(OP_WRITE, gap);
    send_byte(a, gap);
    send_byte(d[15:8], gap);
    send_byte(d[7:0], gap);
    recv_byte(b, stall);
    n_chk++;
    if (b !== RSP_ACK) begin
      n_fail++;
      $display("FAIL write_ack got=%h required=%h", b, RSP_ACK);
    end
    n_chk++;
    if (we_q.size() != 1 || we_q[0] !== {a, d}) begin
      n_fail++;
      $display("FAIL write_port writes=%0d addr/data required %h/%h",
               we_q.size(), a, d);
    end
    model[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input int gap, input int stall);
    logic [7:0] b0;
    logic [7:0] b1;
    send_byte(OP_READ, gap);
    send_byte(a, gap);
    recv_byte(b0, stall);
    recv_byte(b1, stall);
    n_chk++;
    if ({b0, b1} !== model[a]) begin
      n_fail++;
      $display("FAIL read_data addr=%h got=%h required=%h", a, {b0, b1}, model[a]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_data   = 8'h00;
    bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bif.in_ready, bif.out_valid, rf_we, busy, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b required 00000",
               {bif.in_ready, bif.out_valid, rf_we, busy, err});
    end
    n_chk++;
    if ({bif.out_data, rf_waddr, rf_wdata, rf_raddr} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_regs got=%h required 0",
               {bif.out_data, rf_waddr, rf_wdata, rf_raddr});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (bif.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset in_ready=%b busy=%b required 1/0",
               bif.in_ready, busy);
    end
  endtask

  task automatic test_write_basic();
    logic [7:0] b;
    int c0;
    c0 = we_cnt;
    send_byte(8'h57, 0);
    send_byte(8'h05, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 8'h05 || rf_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL commit we=%b addr=%h data=%h required 1/05/beef",
               rf_we, rf_waddr, rf_wdata);
    end
    n_chk++;
    if (bif.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_in_ready got=%b required 0", bif.in_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (rf_we !== 1'b0 || bif.out_valid !== 1'b1 || bif.out_data !== 8'h4B) begin
      n_fail++;
      $display("FAIL ack_phase we=%b valid=%b data=%h required 0/1/4b",
               rf_we, bif.out_valid, bif.out_data);
    end
    recv_byte(b, 0);
    n_chk++;
    if (b !== 8'h4B) begin
      n_fail++;
      $display("FAIL ack_byte got=%h required 4b", b);
    end
    n_chk++;
    if (we_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL we_count got=%0d required 1", we_cnt - c0);
    end
    model[8'h05] = 16'hBEEF;
  endtask

  task automatic test_read_basic();
    logic [7:0] b;
    send_byte(8'h52, 0);
    send_byte(8'h05, 0);
    n_chk++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_phase valid=%b in_ready=%b required 0/0",
               bif.out_valid, bif.in_ready);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (bif.out_valid !== 1'b1 || bif.out_data !== 8'hBE) begin
      n_fail++;
      $display("FAIL first_byte_latency valid=%b data=%h required 1/be",
               bif.out_valid, bif.out_data);
    end
    recv_byte(b, 0);
    n_chk++;
    if (b !== 8'hBE) begin
      n_fail++;
      $display("FAIL read_b0 got=%h required be", b);
    end
    recv_byte(b, 0);
    n_chk++;
    if (b !== 8'hEF) begin
      n_fail++;
      $display("FAIL read_b1 got=%h required ef", b);
    end
    n_chk++;
    if (busy !== 1'b0 || bif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_done busy=%b in_ready=%b required 0/1", busy, bif.in_ready);
    end
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h41, 0);
    n_chk++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse err=%b busy=%b required 1/0", err, busy);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width err=%b required 0", err);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (bif.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_out valid=%b busy=%b required 0/0", bif.out_valid, busy);
    end
    do_read(8'h00, 0, 0);
  endtask

  task automatic test_stall();
    logic [7:0] b;
    int n;
    n = 0;
    bif.out_ready = 1'b0;
    send_byte(8'h52, 0);
    send_byte(8'h05, 0);
    while (bif.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (bif.out_valid !== 1'b1 || bif.out_data !== 8'hBE || bif.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d valid=%b data=%h in_ready=%b required 1/be/0",
                 i, bif.out_valid, bif.out_data, bif.in_ready);
      end
    end
    recv_byte(b, 0);
    n_chk++;
    if (b !== 8'hBE) begin
      n_fail++;
      $display("FAIL stall_b0 got=%h required be", b);
    end
    recv_byte(b, 2);
    n_chk++;
    if (b !== 8'hEF) begin
      n_fail++;
      $display("FAIL stall_b1 got=%h required ef", b);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = we_cnt;
    send_byte(8'h57, 0);
    send_byte(8'h05, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (rf_we !== 1'b0 || bif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid we=%b valid=%b required 0/0", rf_we, bif.out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (we_cnt != c0 || bif.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon writes=%0d valid=%b busy=%b required 0/0/0",
               we_cnt - c0, bif.out_valid, busy);
    end
    do_read(8'h05, 0, 0);
    do_write(8'h07, 16'h1234, 0, 0);
    do_read(8'h07, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1) begin
        d = 16'($urandom);
        do_write(a, d, 3, 3);
      end else begin
        do_read(a, 3, 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_write(8'hA5, 16'hC3D2, 0, 0);
    do_read(8'hA5, 0, 0);
    do_write(8'hA5, 16'h0F0E, 0, 0);
    do_read(8'hA5, 0, 0);
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.in_data   = 8'h00;
    bif.out_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_bad_opcode();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
